// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
//
// Purpose:
//   Shares one DATA_W-bit ALU among NUM_REQ requesters. A round-robin arbiter
//   picks one pending request while idle. The request runs for a latency that
//   depends on the opcode: MUL_CYCLES for MUL, DIV_CYCLES for DIV and one
//   cycle for everything else. The result and the requester index are then
//   returned over a valid/ready response channel.
//   Flow: IDLE (accept) -> EXEC (count down) -> RESP (hold until taken) -> IDLE.
//
// Opcode encoding (operation_t, 3 bits):
//   0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 INVALID
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   DATA_W      operand/result width
//   MUL_CYCLES  EXEC cycles for MUL (>=1)
//   DIV_CYCLES  EXEC cycles for DIV (>=1)
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous, active-low reset
//   req_valid   in   [NUM_REQ]         request pending, per requester
//   req_ready   out  [NUM_REQ]         one-hot accept, only in IDLE
//   req_op      in   [3*NUM_REQ]       opcode per requester, slice i = [3i+2:3i]
//   req_a       in   [DATA_W*NUM_REQ]  operand A per requester
//   req_b       in   [DATA_W*NUM_REQ]  operand B per requester
//   rsp_valid   out  response available
//   rsp_ready   in   consumer accepts response
//   rsp_id      out  [$clog2(NUM_REQ)] requester that issued the operation
//   rsp_result  out  [DATA_W]          result
//   busy        out  high whenever the scheduler is not idle
//   rsp_err     out  (ALU_ERR_FLAG_EN only) INVALID op or divide by zero
//
// Build option:
//   ALU_ERR_FLAG_EN  when defined, adds the rsp_err output. Results are the
//                    same either way.
// ---------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [3*NUM_REQ-1:0]       req_op,
  input  logic [DATA_W*NUM_REQ-1:0]  req_a,
  input  logic [DATA_W*NUM_REQ-1:0]  req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_result,
`ifdef ALU_ERR_FLAG_EN
  output logic                       rsp_err,
`endif
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // The counter holds L-1, so it must reach MAX_L-1.
  localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_DIV     = 3'd3,
    OP_AND     = 3'd4,
    OP_OR      = 3'd5,
    OP_XOR     = 3'd6,
    OP_INVALID = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Per-requester views of the packed input buses
  // -------------------------------------------------------------------------
  logic [2:0]        op_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[3*gi +: 3];
      assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  operation_t        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
`ifdef ALU_ERR_FLAG_EN
  logic              rsp_err_q;
  logic              rsp_err_d;
`endif

  // -------------------------------------------------------------------------
  // Round-robin grant: scan rr_ptr+1, rr_ptr+2, ... with explicit wrap so
  // that non-power-of-two NUM_REQ works. The first valid requester wins.
  // -------------------------------------------------------------------------
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (scan_idx == ID_W'(NUM_REQ - 1)) begin
        scan_idx = '0;
      end else begin
        scan_idx = scan_idx + ID_W'(1);
      end
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Accept is combinational so a requester sees ready in the same cycle it
  // is chosen. It is asserted only while idle.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == ST_IDLE) && grant_found &&
                             (grant_idx == ID_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Accept-side decode: opcode of the winner and its EXEC length minus one
  // -------------------------------------------------------------------------
  operation_t       grant_op_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    grant_op_d = operation_t'(op_arr[grant_idx]);
    case (grant_op_d)
      OP_MUL:  cnt_d = CNT_W'(MUL_CYCLES - 1);
      OP_DIV:  cnt_d = CNT_W'(DIV_CYCLES - 1);
      default: cnt_d = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU on the latched operands. The result is sampled only on the final
  // EXEC cycle, so the operands are stable long before the result is used.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rsp_result_d;

  always_comb begin
    rsp_result_d = '0;
    case (op_q)
      OP_ADD:  rsp_result_d = a_q + b_q;
      OP_SUB:  rsp_result_d = a_q - b_q;
      OP_MUL:  rsp_result_d = a_q * b_q;  // low DATA_W bits of the product
      OP_DIV:  rsp_result_d = (b_q == '0) ? '1 : (a_q / b_q);
      OP_AND:  rsp_result_d = a_q & b_q;
      OP_OR:   rsp_result_d = a_q | b_q;
      OP_XOR:  rsp_result_d = a_q ^ b_q;
      default: rsp_result_d = '0;         // INVALID
    endcase
  end

`ifdef ALU_ERR_FLAG_EN
  always_comb begin
    rsp_err_d = (op_q == OP_INVALID) || ((op_q == OP_DIV) && (b_q == '0));
  end
`endif

  // -------------------------------------------------------------------------
  // Controller. A reset in the middle of an operation discards it: no
  // response is produced for it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      cnt_q        <= '0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
`ifdef ALU_ERR_FLAG_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            op_q     <= grant_op_d;
            a_q      <= a_arr[grant_idx];
            b_q      <= b_arr[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= grant_idx;
            cnt_q    <= cnt_d;
            state_q  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (cnt_q == '0) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= rsp_result_d;
`ifdef ALU_ERR_FLAG_EN
            rsp_err_q    <= rsp_err_d;
`endif
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_RESP: begin
          // rsp_id/rsp_result keep their value after the handshake; only
          // rsp_valid drops.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef ALU_ERR_FLAG_EN
  assign rsp_err    = rsp_err_q;
`endif

endmodule
